// File: rtl/ex_pkg.sv
// ---------------------------------------------------------------------------
// ex_pkg
// Shared definitions for the ID/EX issue stage: ALUOp encodings, ALU select
// codes, the R-type opcodes understood by the ALU control, and the beat
// record that travels through the output and skid registers.
// Ports: none (package).
// ---------------------------------------------------------------------------
package ex_pkg;

   localparam int DATA_WIDTH = 64;
   localparam int SEL_WIDTH  = 4;
   localparam int REG_ADDR_W = 5;

   // ALUOp as produced by the main control unit
   typedef enum logic [1:0] {
      ALUOP_MEM   = 2'b00,
      ALUOP_CBZ   = 2'b01,
      ALUOP_RTYPE = 2'b10,
      ALUOP_RSVD  = 2'b11
   } aluOp_e;

   // ALU select codes
   localparam logic [SEL_WIDTH-1:0] ALU_AND = 4'b0000;
   localparam logic [SEL_WIDTH-1:0] ALU_EOR = 4'b0001;
   localparam logic [SEL_WIDTH-1:0] ALU_ADD = 4'b0010;
   localparam logic [SEL_WIDTH-1:0] ALU_SUB = 4'b0110;

   // R-type opcodes, instruction bits [31:21]
   localparam logic [10:0] OPC_ADD = 11'h458;
   localparam logic [10:0] OPC_SUB = 11'h658;
   localparam logic [10:0] OPC_AND = 11'h450;
   localparam logic [10:0] OPC_EOR = 11'h650;

   // Zero register index, never a forwarding target
   localparam logic [REG_ADDR_W-1:0] REG_XZR = 5'd31;

   // One issued instruction as seen by the ALU and writeback
   typedef struct packed {
      logic [SEL_WIDTH-1:0]  select;
      logic [DATA_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] b;
      logic [REG_ADDR_W-1:0] rd;
      logic                  regWrite;
      logic                  illegal;
   } beat_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// ---------------------------------------------------------------------------
// alu_ctrl_decode
// Pure combinational ALU control: maps ALUOp plus the 11-bit opcode to the
// 4-bit ALU select and flags combinations the ALU does not support.
// Ports:
//   alu_op  in  2   ALUOp from main control
//   opcode  in  11  instruction bits [31:21]
//   select  out 4   ALU select
//   illegal out 1   unsupported ALUOp/opcode (select falls back to add)
// ---------------------------------------------------------------------------
import ex_pkg::*;

module alu_ctrl_decode (
   input  logic [1:0]           alu_op,
   input  logic [10:0]          opcode,
   output logic [SEL_WIDTH-1:0] select,
   output logic                 illegal
);

   // Memory ops and CBZ have fixed selects; only R-type looks at the opcode.
   // Anything unrecognised still drives add so the ALU sees a defined select,
   // and the illegal flag lets later stages raise the exception.
   always_comb begin
      select  = ALU_ADD;
      illegal = 1'b0;
      case (aluOp_e'(alu_op))
         ALUOP_MEM: select = ALU_ADD;
         ALUOP_CBZ: select = ALU_SUB;
         ALUOP_RTYPE: begin
            case (opcode)
               OPC_ADD: select = ALU_ADD;
               OPC_SUB: select = ALU_SUB;
               OPC_AND: select = ALU_AND;
               OPC_EOR: select = ALU_EOR;
               default: begin
                  select  = ALU_ADD;
                  illegal = 1'b1;
               end
            endcase
         end
         default: begin
            select  = ALU_ADD;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/ex_issue_stage.sv
// ---------------------------------------------------------------------------
// ex_issue_stage
// ID/EX pipeline stage feeding the 64-bit ALU. Decodes the ALU select,
// picks operand B, and registers the beat. A one-entry skid register behind
// the output register lets id_ready come straight from a flop.
// Optional feature: define EX_FORWARD_EN to add a single forwarding source
// applied to rs1/rs2 at capture time.
// Ports:
//   clk, rst_n (sync, active-low), flush (sync, drops all beats)
//   ID side : id_valid, id_ready, id_alu_op, id_opcode, id_rs1_data,
//             id_rs2_data, id_imm, id_alu_src, id_rd, id_reg_write
//   EX side : ex_valid, ex_ready, alu_select, alu_a, alu_b, ex_rd,
//             ex_reg_write, ex_illegal
//   EX_FORWARD_EN only: id_rs1, id_rs2, fwd_valid, fwd_rd, fwd_data
// ---------------------------------------------------------------------------
import ex_pkg::*;

module ex_issue_stage #(
   parameter int DATA_WIDTH = ex_pkg::DATA_WIDTH,
   parameter int SEL_WIDTH  = ex_pkg::SEL_WIDTH,
   parameter int REG_ADDR_W = ex_pkg::REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  id_valid,
   output logic                  id_ready,
   input  logic [1:0]            id_alu_op,
   input  logic [10:0]           id_opcode,
   input  logic [DATA_WIDTH-1:0] id_rs1_data,
   input  logic [DATA_WIDTH-1:0] id_rs2_data,
   input  logic [DATA_WIDTH-1:0] id_imm,
   input  logic                  id_alu_src,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
`ifdef EX_FORWARD_EN
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  fwd_valid,
   input  logic [REG_ADDR_W-1:0] fwd_rd,
   input  logic [DATA_WIDTH-1:0] fwd_data,
`endif
   output logic                  ex_valid,
   input  logic                  ex_ready,
   output logic [SEL_WIDTH-1:0]  alu_select,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  ex_reg_write,
   output logic                  ex_illegal
);

   logic [SEL_WIDTH-1:0]  decSelect;
   logic                  decIllegal;
   logic [DATA_WIDTH-1:0] opA;
   logic [DATA_WIDTH-1:0] opRs2;
   beat_t                 newBeat;

   beat_t outBeat_q,   outBeat_d;
   logic  outValid_q,  outValid_d;
   beat_t skidBeat_q,  skidBeat_d;
   logic  skidValid_q, skidValid_d;

   logic accept;
   logic transfer;

   alu_ctrl_decode uDecode (
      .alu_op  (id_alu_op),
      .opcode  (id_opcode),
      .select  (decSelect),
      .illegal (decIllegal)
   );

`ifdef EX_FORWARD_EN
   // Bypass the register file when the forwarding source writes the same
   // register; XZR always reads as the register-file value.
   always_comb begin
      opA   = id_rs1_data;
      opRs2 = id_rs2_data;
      if (fwd_valid && (fwd_rd == id_rs1) && (fwd_rd != REG_XZR)) begin
         opA = fwd_data;
      end
      if (fwd_valid && (fwd_rd == id_rs2) && (fwd_rd != REG_XZR)) begin
         opRs2 = fwd_data;
      end
   end
`else
   // Operands come straight from the register file read ports
   always_comb begin
      opA   = id_rs1_data;
      opRs2 = id_rs2_data;
   end
`endif

   // Assemble the incoming beat; the immediate mux sits after forwarding
   always_comb begin
      newBeat.select   = decSelect;
      newBeat.a        = opA;
      newBeat.b        = id_alu_src ? id_imm : opRs2;
      newBeat.rd       = id_rd;
      newBeat.regWrite = id_reg_write;
      newBeat.illegal  = decIllegal;
   end

   // Ready depends only on the skid flop, so EX back-pressure never forms a
   // combinational path back into ID.
   assign id_ready = rst_n && !skidValid_q;
   assign accept   = id_valid && id_ready;
   assign transfer = outValid_q && ex_ready;

   // Next-state for output and skid registers. The skid is only ever loaded
   // while the output is full and stalled, and it drains into the output on
   // the next transfer; id_ready is low in that cycle so no beat competes.
   // Flush clears only the valid bits and wins over everything else.
   always_comb begin
      outBeat_d   = outBeat_q;
      outValid_d  = outValid_q;
      skidBeat_d  = skidBeat_q;
      skidValid_d = skidValid_q;
      if (flush) begin
         outValid_d  = 1'b0;
         skidValid_d = 1'b0;
      end else if (transfer) begin
         if (skidValid_q) begin
            outBeat_d   = skidBeat_q;
            outValid_d  = 1'b1;
            skidValid_d = 1'b0;
         end else if (accept) begin
            outBeat_d  = newBeat;
            outValid_d = 1'b1;
         end else begin
            outValid_d = 1'b0;
         end
      end else if (!outValid_q) begin
         if (accept) begin
            outBeat_d  = newBeat;
            outValid_d = 1'b1;
         end
      end else if (accept) begin
         skidBeat_d  = newBeat;
         skidValid_d = 1'b1;
      end
   end

   // State registers with synchronous reset that also zeroes the data path
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         outBeat_q   <= '0;
         outValid_q  <= 1'b0;
         skidBeat_q  <= '0;
         skidValid_q <= 1'b0;
      end else begin
         outBeat_q   <= outBeat_d;
         outValid_q  <= outValid_d;
         skidBeat_q  <= skidBeat_d;
         skidValid_q <= skidValid_d;
      end
   end

   assign ex_valid     = outValid_q;
   assign alu_select   = outBeat_q.select;
   assign alu_a        = outBeat_q.a;
   assign alu_b        = outBeat_q.b;
   assign ex_rd        = outBeat_q.rd;
   assign ex_reg_write = outBeat_q.regWrite;
   assign ex_illegal   = outBeat_q.illegal;

endmodule

// File: tb/tb_ex_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_issue_stage
// Self-checking bench for ex_issue_stage. A queue model tracks which beats
// the stage holds and what each must look like on the ALU side; directed
// vectors cover decode, operand select, stall/skid, flush and reset.
// Define EX_FORWARD_EN to build and exercise the forwarding ports.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ex_issue_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        id_valid;
   logic        id_ready;
   logic [1:0]  id_alu_op;
   logic [10:0] id_opcode;
   logic [63:0] id_rs1_data;
   logic [63:0] id_rs2_data;
   logic [63:0] id_imm;
   logic        id_alu_src;
   logic [4:0]  id_rd;
   logic        id_reg_write;
   logic        ex_valid;
   logic        ex_ready;
   logic [3:0]  alu_select;
   logic [63:0] alu_a;
   logic [63:0] alu_b;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        ex_illegal;
`ifdef EX_FORWARD_EN
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [63:0] fwd_data;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0]  sel;
      logic [63:0] a;
      logic [63:0] b;
      logic [4:0]  rd;
      logic        rw;
      logic        ill;
   } expBeat_t;

   expBeat_t   modelQ[$];
   logic [4:0] doneRd[$];

   ex_issue_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .id_valid     (id_valid),
      .id_ready     (id_ready),
      .id_alu_op    (id_alu_op),
      .id_opcode    (id_opcode),
      .id_rs1_data  (id_rs1_data),
      .id_rs2_data  (id_rs2_data),
      .id_imm       (id_imm),
      .id_alu_src   (id_alu_src),
      .id_rd        (id_rd),
      .id_reg_write (id_reg_write),
`ifdef EX_FORWARD_EN
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .fwd_valid    (fwd_valid),
      .fwd_rd       (fwd_rd),
      .fwd_data     (fwd_data),
`endif
      .ex_valid     (ex_valid),
      .ex_ready     (ex_ready),
      .alu_select   (alu_select),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .ex_rd        (ex_rd),
      .ex_reg_write (ex_reg_write),
      .ex_illegal   (ex_illegal)
   );

   // Free-running clock, first rising edge at 5ns
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // What the ALU must receive for the instruction currently on the ID bus,
   // written straight from the instruction-set meaning of ALUOp/opcode
   function automatic expBeat_t modelBeat();
      expBeat_t   e;
      logic [63:0] rs1v;
      logic [63:0] rs2v;
      rs1v = id_rs1_data;
      rs2v = id_rs2_data;
`ifdef EX_FORWARD_EN
      if (fwd_valid && fwd_rd == id_rs1 && fwd_rd != 5'd31) rs1v = fwd_data;
      if (fwd_valid && fwd_rd == id_rs2 && fwd_rd != 5'd31) rs2v = fwd_data;
`endif
      e.ill = 1'b0;
      if (id_alu_op == 2'd0)      e.sel = 4'd2;
      else if (id_alu_op == 2'd1) e.sel = 4'd6;
      else if (id_alu_op == 2'd2 && id_opcode == 11'h458) e.sel = 4'd2;
      else if (id_alu_op == 2'd2 && id_opcode == 11'h658) e.sel = 4'd6;
      else if (id_alu_op == 2'd2 && id_opcode == 11'h450) e.sel = 4'd0;
      else if (id_alu_op == 2'd2 && id_opcode == 11'h650) e.sel = 4'd1;
      else begin
         e.sel = 4'd2;
         e.ill = 1'b1;
      end
      e.a  = rs1v;
      e.b  = id_alu_src ? id_imm : rs2v;
      e.rd = id_rd;
      e.rw = id_reg_write;
      return e;
   endfunction

   // Compare process: inputs are stable at the falling edge, so check the
   // DUT against the model, then advance the model over the coming edge.
   always @(negedge clk) begin
      int  held;
      bit  acc;
      bit  xfer;
      held = modelQ.size();
      checkOutput("ex_valid", ex_valid, held > 0);
      checkOutput("id_ready", id_ready, rst_n && held < 2);
      if (ex_valid && held > 0) begin
         checkOutput("alu_select", alu_select, modelQ[0].sel);
         checkOutput("alu_a", alu_a, modelQ[0].a);
         checkOutput("alu_b", alu_b, modelQ[0].b);
         checkOutput("ex_rd", ex_rd, modelQ[0].rd);
         checkOutput("ex_reg_write", ex_reg_write, modelQ[0].rw);
         checkOutput("ex_illegal", ex_illegal, modelQ[0].ill);
      end
      acc  = id_valid && rst_n && held < 2;
      xfer = ex_ready && held > 0;
      if (!rst_n || flush) begin
         modelQ.delete();
      end else begin
         if (xfer) begin
            doneRd.push_back(modelQ[0].rd);
            void'(modelQ.pop_front());
         end
         if (acc) modelQ.push_back(modelBeat());
      end
   end

   // Put one instruction on the ID bus (raises id_valid)
   task automatic applyStimulus(input logic [1:0] op, input logic [10:0] opc,
                                input logic [63:0] r1, input logic [63:0] r2,
                                input logic [63:0] im, input logic src,
                                input logic [4:0] rdv, input logic rw);
      id_valid     = 1'b1;
      id_alu_op    = op;
      id_opcode    = opc;
      id_rs1_data  = r1;
      id_rs2_data  = r2;
      id_imm       = im;
      id_alu_src   = src;
      id_rd        = rdv;
      id_reg_write = rw;
   endtask

   // Hold the beat until it is accepted (bounded), then drop id_valid
   task automatic waitAccept();
      bit acc;
      int n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = id_ready;
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("accept_timeout", acc, 1);
      id_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      id_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n        = 1'b0;
      flush        = 1'b0;
      id_valid     = 1'b0;
      id_alu_op    = '0;
      id_opcode    = '0;
      id_rs1_data  = '0;
      id_rs2_data  = '0;
      id_imm       = '0;
      id_alu_src   = 1'b0;
      id_rd        = '0;
      id_reg_write = 1'b0;
      ex_ready     = 1'b1;
`ifdef EX_FORWARD_EN
      id_rs1    = '0;
      id_rs2    = '0;
      fwd_valid = 1'b0;
      fwd_rd    = '0;
      fwd_data  = '0;
`endif

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_id_ready", id_ready, 0);
      checkOutput("rst_ex_valid", ex_valid, 0);
      checkOutput("rst_alu_a", alu_a, 0);
      checkOutput("rst_alu_select", alu_select, 0);
      checkOutput("rst_ex_rd", ex_rd, 0);
      rst_n = 1'b1;
      #1;
      checkOutput("release_id_ready", id_ready, 1);

      // SUB R-type, register operand
      applyStimulus(2'b10, 11'h658, 64'd100, 64'd30, 64'd0, 1'b0, 5'd1, 1'b1);
      waitAccept();
      checkOutput("sub_valid", ex_valid, 1);
      checkOutput("sub_select", alu_select, 4'b0110);
      checkOutput("sub_a", alu_a, 64'd100);
      checkOutput("sub_b", alu_b, 64'd30);
      checkOutput("sub_illegal", ex_illegal, 0);

      // Load/store add with negative immediate
      applyStimulus(2'b00, 11'h7C2, 64'd500, 64'd55, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 5'd2, 1'b1);
      waitAccept();
      checkOutput("mem_select", alu_select, 4'b0010);
      checkOutput("mem_b", alu_b, 64'hFFFF_FFFF_FFFF_FFF8);

      // Remaining decodes back to back
      applyStimulus(2'b01, 11'h5A0, 64'd9, 64'd0, 64'd0, 1'b0, 5'd3, 1'b0);
      waitAccept();
      checkOutput("cbz_select", alu_select, 4'b0110);
      applyStimulus(2'b10, 11'h450, 64'hF0F0, 64'h0FF0, 64'd0, 1'b0, 5'd4, 1'b1);
      waitAccept();
      checkOutput("and_select", alu_select, 4'b0000);
      applyStimulus(2'b10, 11'h650, 64'hAAAA, 64'h5555, 64'd0, 1'b0, 5'd5, 1'b1);
      waitAccept();
      checkOutput("eor_select", alu_select, 4'b0001);
      applyStimulus(2'b10, 11'h458, 64'd1, 64'd2, 64'd0, 1'b0, 5'd6, 1'b1);
      waitAccept();
      checkOutput("add_select", alu_select, 4'b0010);

      // Unsupported opcode and reserved ALUOp
      applyStimulus(2'b10, 11'h550, 64'd7, 64'd8, 64'd0, 1'b0, 5'd7, 1'b1);
      waitAccept();
      checkOutput("badopc_select", alu_select, 4'b0010);
      checkOutput("badopc_illegal", ex_illegal, 1);
      applyStimulus(2'b11, 11'h458, 64'd7, 64'd8, 64'd0, 1'b0, 5'd8, 1'b1);
      waitAccept();
      checkOutput("rsvd_select", alu_select, 4'b0010);
      checkOutput("rsvd_illegal", ex_illegal, 1);

      // Stall: A to output, B to skid, C held upstream
      idle(3);
      doneRd.delete();
      ex_ready = 1'b0;
      applyStimulus(2'b10, 11'h458, 64'd11, 64'd1, 64'd0, 1'b0, 5'd10, 1'b1);
      waitAccept();
      applyStimulus(2'b10, 11'h658, 64'd22, 64'd2, 64'd0, 1'b0, 5'd11, 1'b1);
      waitAccept();
      checkOutput("skid_full_ready", id_ready, 0);
      applyStimulus(2'b00, 11'h000, 64'd33, 64'd3, 64'd40, 1'b1, 5'd12, 1'b1);
      repeat (3) begin
         @(posedge clk);
         #1;
         checkOutput("stall_ready", id_ready, 0);
         checkOutput("stall_hold_rd", ex_rd, 5'd10);
      end
      ex_ready = 1'b1;
      waitAccept();
      idle(4);
      checkOutput("order_count", doneRd.size(), 3);
      if (doneRd.size() == 3) begin
         checkOutput("order_0", doneRd[0], 5'd10);
         checkOutput("order_1", doneRd[1], 5'd11);
         checkOutput("order_2", doneRd[2], 5'd12);
      end

      // Flush with output and skid full and a beat on offer
      doneRd.delete();
      ex_ready = 1'b0;
      applyStimulus(2'b00, 11'h000, 64'd1, 64'd1, 64'd1, 1'b1, 5'd20, 1'b1);
      waitAccept();
      applyStimulus(2'b00, 11'h000, 64'd2, 64'd2, 64'd2, 1'b1, 5'd21, 1'b1);
      waitAccept();
      applyStimulus(2'b00, 11'h000, 64'd3, 64'd3, 64'd3, 1'b1, 5'd22, 1'b1);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      id_valid = 1'b0;
      checkOutput("flush_ex_valid", ex_valid, 0);
      checkOutput("flush_id_ready", id_ready, 1);
      ex_ready = 1'b1;
      idle(4);
      checkOutput("flush_nothing_out", doneRd.size(), 0);

      // Beat accepted during a flush with the stage empty is discarded
      applyStimulus(2'b00, 11'h000, 64'd4, 64'd4, 64'd4, 1'b1, 5'd23, 1'b1);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      id_valid = 1'b0;
      checkOutput("flush_accept_valid", ex_valid, 0);
      idle(3);
      checkOutput("flush_accept_out", doneRd.size(), 0);
      applyStimulus(2'b01, 11'h000, 64'd5, 64'd6, 64'd0, 1'b0, 5'd24, 1'b0);
      waitAccept();
      checkOutput("post_flush_rd", ex_rd, 5'd24);
      idle(2);

      // Reset in the middle of a stall drops both beats
      doneRd.delete();
      ex_ready = 1'b0;
      applyStimulus(2'b10, 11'h450, 64'd77, 64'd88, 64'd0, 1'b0, 5'd25, 1'b1);
      waitAccept();
      applyStimulus(2'b10, 11'h650, 64'd99, 64'd11, 64'd0, 1'b0, 5'd26, 1'b1);
      waitAccept();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("midrst_valid", ex_valid, 0);
      checkOutput("midrst_alu_a", alu_a, 0);
      checkOutput("midrst_ex_rd", ex_rd, 0);
      checkOutput("midrst_ready", id_ready, 0);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      ex_ready = 1'b1;
      idle(3);
      checkOutput("midrst_nothing_out", doneRd.size(), 0);

`ifdef EX_FORWARD_EN
      // Forwarding hit on rs1, then XZR which must not forward
      fwd_valid = 1'b1;
      fwd_rd    = 5'd5;
      fwd_data  = 64'd7;
      id_rs1    = 5'd5;
      id_rs2    = 5'd6;
      applyStimulus(2'b00, 11'h000, 64'd100, 64'd200, 64'd0, 1'b0, 5'd9, 1'b1);
      waitAccept();
      checkOutput("fwd_a", alu_a, 64'd7);
      checkOutput("fwd_b_untouched", alu_b, 64'd200);
      fwd_rd = 5'd31;
      id_rs1 = 5'd31;
      applyStimulus(2'b00, 11'h000, 64'd123, 64'd200, 64'd0, 1'b0, 5'd9, 1'b1);
      waitAccept();
      checkOutput("fwd_xzr_a", alu_a, 64'd123);
      fwd_rd = 5'd6;
      applyStimulus(2'b00, 11'h000, 64'd1, 64'd200, 64'd0, 1'b0, 5'd9, 1'b1);
      waitAccept();
      checkOutput("fwd_b", alu_b, 64'd7);
      fwd_valid = 1'b0;
      idle(3);
`endif

      checkOutput("model_drained", modelQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ex_issue_stage.md
Name: ex_issue_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the 64-bit ALU.
- Accepts decoded instructions from ID over a valid/ready handshake and generates the 4-bit ALU select from ALUOp plus the 11-bit opcode.
- Selects operand B (register or immediate) and presents registered select, A and B to the ALU together with writeback tags.
- A 2-entry skid buffer keeps id_ready fully registered so back-pressure from EX does not create a combinational path.

Parameters:
- DATA_WIDTH, 64, operand/immediate width; matches the ALU data width.
- SEL_WIDTH, 4, ALU select width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- flush  input  1  synchronous pipeline flush (branch taken).
- id_valid  input  1  ID beat valid.
- id_ready  output  1  stage can accept a beat.
- id_alu_op  input  2  ALUOp from main control.
- id_opcode  input  11  instruction bits [31:21].
- id_rs1_data  input  DATA_WIDTH  register read port 1.
- id_rs2_data  input  DATA_WIDTH  register read port 2.
- id_imm  input  DATA_WIDTH  sign-extended immediate.
- id_alu_src  input  1  1 = operand B is id_imm.
- id_rd  input  REG_ADDR_W  destination register.
- id_reg_write  input  1  writeback enable.
- ex_valid  output  1  ALU operands valid.
- ex_ready  input  1  EX consumes the beat.
- alu_select  output  SEL_WIDTH  to ALU select.
- alu_a  output  DATA_WIDTH  to ALU A.
- alu_b  output  DATA_WIDTH  to ALU B.
- ex_rd  output  REG_ADDR_W  destination tag.
- ex_reg_write  output  1  writeback enable tag.
- ex_illegal  output  1  unsupported ALUOp/opcode.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset values: ex_valid=0, skid_valid=0, and all data outputs =0. id_ready=0 while rst_n=0, and 1 in the first cycle after release.
- Decode (combinational on ID inputs, then registered):
  - ALUOp 00 -> 0010 (add, LDUR/STUR).
  - ALUOp 01 -> 0110 (sub, CBZ).
  - ALUOp 10 -> decode by opcode: 11'h458 ADD->0010, 11'h658 SUB->0110, 11'h450 AND->0000, 11'h650 EOR->0001.
  - Any other R-type opcode, or ALUOp 11 -> select 0010 with ex_illegal=1.
- Operands: alu_a=id_rs1_data; alu_b = id_alu_src ? id_imm : id_rs2_data. No width change.
- Handshake:
  - Accept occurs when id_valid && id_ready. Transfer occurs when ex_valid && ex_ready.
  - id_ready = rst_n && !skid_valid (skid_valid is a register).
  - Accepted beat goes to the output register if it is empty or transferring in the same cycle; otherwise it goes to the skid register.
  - On transfer with skid_valid=1, the skid moves to the output and skid_valid clears. If a new accept happens the same cycle, it cannot, because id_ready was 0.
- Latency: 1 cycle from accept to ex_valid when unstalled.
- Throughput: 1 beat/cycle. Order is strictly preserved.
- Stall: when ex_valid=1 and ex_ready=0, all output registers hold stable.
- Flush:
  - Next cycle ex_valid=0 and skid_valid=0.
  - Any beat accepted in the flush cycle is discarded.
  - Flush has priority over accept and transfer.
  - Data registers may hold stale values; only valid bits clear.
- Reset mid-stall: all beats are dropped and no output changes other than the reset values.

Optional Feature:
- Macro: EX_FORWARD_EN.
- With macro defined, extra ports are added: id_rs1 / id_rs2 (REG_ADDR_W, in), fwd_valid (1, in), fwd_rd (REG_ADDR_W, in), fwd_data (DATA_WIDTH, in).
- Forwarding rule at capture (output or skid load):
  - If fwd_valid && fwd_rd==id_rs1 && fwd_rd!=31, operand A is taken from fwd_data.
  - The same rule applies to rs2 before the alu_src mux.
  - Register 31 (XZR) is never forwarded.
- Without the macro: none of these ports exist and operands come straight from the register file.

Decomposition:
- Package ex_pkg holds:
  - ALUOp encodings.
  - ALU select constants: ALU_AND=4'b0000, ALU_EOR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110.
  - R-type opcode constants.
  - Beat struct typedef: select, a, b, rd, reg_write, illegal.
- Sub-module alu_ctrl_decode holds the pure combinational ALUOp/opcode -> select/illegal mapping. The skid/output registers stay in the top module.

Test Plan:
- Reset then accept ALUOp=10, opcode=11'h658, rs1=100, rs2=30, alu_src=0, with ex_ready=1 -> next cycle ex_valid=1, alu_select=0110, alu_a=100, alu_b=30, ex_illegal=0.
- ALUOp=00, alu_src=1, imm=0xFFFF_FFFF_FFFF_FFF8 -> alu_select=0010, alu_b=imm.
- Hold ex_ready=0, issue 3 consecutive beats (A, B, C):
  - id_ready drops to 0 after B is skidded; C is held upstream.
  - Raise ex_ready -> outputs A, B, C in order with no loss or duplication.
- Assert flush while output and skid are both full, and id_valid=1 -> next cycle ex_valid=0 and id_ready=1, and the flushed beats never appear.
- ALUOp=10 with opcode=11'h550, and separately ALUOp=11 -> alu_select=0010, ex_illegal=1.
- With EX_FORWARD_EN defined: fwd_valid=1, fwd_rd=5, id_rs1=5, fwd_data=7 -> alu_a=7. Repeat with fwd_rd=id_rs1=31 -> alu_a=id_rs1_data.
